pipe_skid_reg: RTL and testbench

//  Generic elastic pipeline register for inter-stage boundaries (F/D, D/E, E/M, M/W).

---
 rtl/pipe_skid_reg_if.sv | 27 ++
 rtl/pipe_skid_reg.sv | 98 +++++++++
 tb/tb_pipe_skid_reg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for one elastic pipeline boundary.
// The slave side is the register itself; the master side is the surrounding
// stages (upstream producer plus downstream consumer) or a testbench.
interface pipe_skid_reg_if #(
  parameter int PAYLOAD_W = 104,
  parameter int CNT_W     = 16
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_data;
  logic [1:0]           occupancy;
  logic [CNT_W-1:0]     stall_cnt;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a 2-entry skid buffer.
// in_ready is a function of registered state only, so no combinational ready
// path crosses a stage boundary. The main register is always the FIFO head;
// the skid register only ever holds the younger of two entries.
module pipe_skid_reg #(
  parameter int PAYLOAD_W = 104,
  parameter int CNT_W     = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [PAYLOAD_W-1:0] mainData_q, mainData_d;
  logic [PAYLOAD_W-1:0] skidData_q, skidData_d;
  logic [CNT_W-1:0]     stallCnt_q, stallCnt_d;

  logic inFire;
  logic outFire;

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = mainData_q;
  assign bus.occupancy = state_q;
  assign bus.stall_cnt = stallCnt_q;

  assign inFire  = bus.in_valid & bus.in_ready;
  assign outFire = bus.out_valid & bus.out_ready;

  // Next occupancy and data moves; flush overrides everything and leaves data regs untouched.
  always_comb begin
    state_d    = state_q;
    mainData_d = mainData_q;
    skidData_d = skidData_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (inFire) begin
            state_d    = ONE;
            mainData_d = bus.in_data;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            mainData_d = bus.in_data;
          end else if (inFire) begin
            state_d    = FULL;
            skidData_d = bus.in_data;
          end else if (outFire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (outFire) begin
            state_d    = ONE;
            mainData_d = skidData_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where the head is offered but not taken, flush cycle included.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (bus.out_valid && !bus.out_ready && (stallCnt_q != CNT_MAX)) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  // State, payload and counter registers; reset drops any held entries immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      mainData_q <= '0;
      skidData_q <= '0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mainData_q <= mainData_d;
      skidData_q <= skidData_d;
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg with a data scoreboard: every accepted
// input is queued, every delivered head is popped and compared in order.
module tb_pipe_skid_reg;

  localparam int PW = 104;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [PW-1:0] sb[$];

  pipe_skid_reg_if #(.PAYLOAD_W(PW), .CNT_W(CW)) bus ();

  pipe_skid_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, score the handshakes that will fire at the
  // coming rising edge, then return 1 time unit after that edge.
  task automatic applyStimulus(input logic v, input logic [PW-1:0] d,
                               input logic ordy, input logic fl);
    logic [PW-1:0] expData;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", bus.out_data, '1);
      end else begin
        expData = sb.pop_front();
        checkOutput("out_data", bus.out_data, expData);
      end
    end
    if (fl) sb.delete();
    else if (bus.in_valid && bus.in_ready) sb.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #12;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_occ", bus.occupancy, 0);
    checkOutput("rst_stall", bus.stall_cnt, 0);
    rst = 1'b0;

    // T1: fill to FULL, then assert reset asynchronously mid-cycle
    applyStimulus(1'b1, PW'(1), 1'b0, 1'b0);
    applyStimulus(1'b1, PW'(2), 1'b0, 1'b0);
    checkOutput("t1_occ_full", bus.occupancy, 2);
    checkOutput("t1_stall_pre", bus.stall_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t1_out_valid", bus.out_valid, 0);
    checkOutput("t1_in_ready", bus.in_ready, 1);
    checkOutput("t1_occ", bus.occupancy, 0);
    checkOutput("t1_stall", bus.stall_cnt, 0);
    sb.delete();
    doReset();

    // T2: streaming with out_ready held high
    applyStimulus(1'b1, PW'('hA), 1'b1, 1'b0);
    checkOutput("t2_in_ready0", bus.in_ready, 1);
    checkOutput("t2_head_a", bus.out_data, 'hA);
    applyStimulus(1'b1, PW'('hB), 1'b1, 1'b0);
    checkOutput("t2_in_ready1", bus.in_ready, 1);
    checkOutput("t2_head_b", bus.out_data, 'hB);
    applyStimulus(1'b1, PW'('hC), 1'b1, 1'b0);
    checkOutput("t2_in_ready2", bus.in_ready, 1);
    checkOutput("t2_occ", bus.occupancy, 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t2_drained", bus.out_valid, 0);

    // T3: back-pressure fills the skid, then drains in order
    doReset();
    applyStimulus(1'b1, PW'('h11), 1'b0, 1'b0);
    applyStimulus(1'b1, PW'('h22), 1'b0, 1'b0);
    checkOutput("t3_occ_full", bus.occupancy, 2);
    checkOutput("t3_in_ready0", bus.in_ready, 0);
    checkOutput("t3_head", bus.out_data, 'h11);
    applyStimulus(1'b1, PW'('h99), 1'b0, 1'b0);
    checkOutput("t3_head_hold", bus.out_data, 'h11);
    checkOutput("t3_stall", bus.stall_cnt, 2);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t3_in_ready1", bus.in_ready, 1);
    checkOutput("t3_occ_one", bus.occupancy, 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t3_occ_empty", bus.occupancy, 0);
    checkOutput("t3_stall_hold", bus.stall_cnt, 2);

    // T4: flush while FULL with a pending input, then flush during pop/push in ONE
    doReset();
    applyStimulus(1'b1, PW'('h31), 1'b0, 1'b0);
    applyStimulus(1'b1, PW'('h32), 1'b0, 1'b0);
    applyStimulus(1'b1, PW'('h33), 1'b0, 1'b1);
    checkOutput("t4_out_valid", bus.out_valid, 0);
    checkOutput("t4_occ", bus.occupancy, 0);
    checkOutput("t4_stall", bus.stall_cnt, 2);
    applyStimulus(1'b1, PW'('h34), 1'b0, 1'b0);
    applyStimulus(1'b1, PW'('h35), 1'b1, 1'b1);
    checkOutput("t4_occ2", bus.occupancy, 0);
    applyStimulus(1'b1, PW'('h36), 1'b1, 1'b0);
    checkOutput("t4_head_after", bus.out_data, 'h36);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t4_empty", bus.out_valid, 0);

    // T5: simultaneous push and pop while holding one entry
    doReset();
    applyStimulus(1'b1, PW'('h44), 1'b1, 1'b0);
    applyStimulus(1'b1, PW'('h55), 1'b1, 1'b0);
    checkOutput("t5_occ", bus.occupancy, 1);
    checkOutput("t5_head", bus.out_data, 'h55);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // T6: stall counter saturates at 2^CW-1
    doReset();
    applyStimulus(1'b1, PW'('h66), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t6_stall_mid", bus.stall_cnt, 10);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t6_stall_sat", bus.stall_cnt, 15);
    checkOutput("t6_head", bus.out_data, 'h66);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t6_stall_keep", bus.stall_cnt, 15);

    checkOutput("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
